mc_control_unit: RTL and testbench



---
 rtl/mc_control_unit_if.sv | 33 +++
 rtl/mc_control_unit.sv | 178 +++++++++++++++++
 tb/tb_mc_control_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_if.sv
// -----------------------------------------------------------------------------
// mc_control_unit_if
// Byte-wide memory bus between the control unit (master) and the unified
// memory (slave). Single request/ready handshake: an access completes at the
// rising edge where mem_req and mem_ready are both high.
//   mem_req    master->slave  access request, held until accepted
//   mem_we     master->slave  1 = write, 0 = read
//   mem_addr   master->slave  access address
//   mem_wdata  master->slave  write data
//   mem_rdata  slave->master  read data, valid while mem_ready is high
//   mem_ready  slave->master  access completes this cycle
// -----------------------------------------------------------------------------
interface mc_control_unit_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Fetches a 16-bit instruction as two bytes ({op[2:0], a[12:8]} then a[7:0]),
// then reads or writes the operand and updates the accumulator.
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   bus        memory bus (master side of mc_control_unit_if)
//   acc_addr   accumulator index, always 0
//   acc_wdata  accumulator write data (0 outside EXEC)
//   acc_we     accumulator write enable, one-cycle pulse per ALU/LDA op
//   acc_rdata  accumulator read data (combinational from register file)
//   carry      carry/borrow flag, changed only by ADD and SUB
//   halted     high once HLT has executed
//   pc         program counter
// -----------------------------------------------------------------------------
module mc_control_unit #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   mc_control_unit_if.master bus,
   output logic [ADDR_W-1:0] acc_addr,
   output logic [DATA_W-1:0] acc_wdata,
   output logic              acc_we,
   input  logic [DATA_W-1:0] acc_rdata,
   output logic              carry,
   output logic              halted,
   output logic [ADDR_W-1:0] pc
);

   typedef enum logic [2:0] {
      INIT, FETCH1, FETCH2, DECODE, MEMRD, EXEC, MEMWR, HALT
   } state_t;

   typedef enum logic [2:0] {
      OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_JMP, OP_JZ, OP_HLT
   } op_t;

   state_t            state, stateNext;
   logic [ADDR_W-1:0] pcNext;
   logic [DATA_W-1:0] irHi, irHiNext;
   logic [DATA_W-1:0] irLo, irLoNext;
   logic [DATA_W-1:0] mdr, mdrNext;
   logic              carryNext;

   op_t               opcode;
   logic [ADDR_W-1:0] operandAddr;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;

   assign opcode      = op_t'(irHi[DATA_W-1 -: 3]);
   assign operandAddr = {irHi[ADDR_W-DATA_W-1:0], irLo};
   // Ninth bit of the widened sum is the carry; of the difference, the borrow.
   assign sum         = {1'b0, acc_rdata} + {1'b0, mdr};
   assign diff        = {1'b0, acc_rdata} - {1'b0, mdr};
   assign acc_addr    = '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         pc    <= '0;
         irHi  <= '0;
         irLo  <= '0;
         mdr   <= '0;
         carry <= 1'b0;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
         irHi  <= irHiNext;
         irLo  <= irLoNext;
         mdr   <= mdrNext;
         carry <= carryNext;
      end
   end

   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      stateNext     = state;
      pcNext        = pc;
      irHiNext      = irHi;
      irLoNext      = irLo;
      mdrNext       = mdr;
      carryNext     = carry;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      acc_we        = 1'b0;
      acc_wdata     = '0;
      halted        = 1'b0;

      unique case (state)
         INIT: stateNext = FETCH1;

         FETCH1: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc;
            if (bus.mem_ready) begin
               irHiNext  = bus.mem_rdata;
               pcNext    = pc + ADDR_W'(1);
               stateNext = FETCH2;
            end
         end

         FETCH2: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = pc;
            if (bus.mem_ready) begin
               irLoNext  = bus.mem_rdata;
               pcNext    = pc + ADDR_W'(1);
               stateNext = DECODE;
            end
         end

         DECODE: begin
            unique case (opcode)
               OP_JMP: begin
                  pcNext    = operandAddr;
                  stateNext = FETCH1;
               end
               OP_JZ: begin
                  // Reads the live accumulator, so an EXEC write just before is seen.
                  if (acc_rdata == '0) pcNext = operandAddr;
                  stateNext = FETCH1;
               end
               OP_HLT:  stateNext = HALT;
               OP_STA:  stateNext = MEMWR;
               default: stateNext = MEMRD;
            endcase
         end

         MEMRD: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = operandAddr;
            if (bus.mem_ready) begin
               mdrNext   = bus.mem_rdata;
               stateNext = EXEC;
            end
         end

         EXEC: begin
            acc_we = 1'b1;
            unique case (opcode)
               OP_ADD: begin
                  acc_wdata = sum[DATA_W-1:0];
                  carryNext = sum[DATA_W];
               end
               OP_SUB: begin
                  acc_wdata = diff[DATA_W-1:0];
                  carryNext = diff[DATA_W];
               end
               OP_AND:  acc_wdata = acc_rdata & mdr;
               default: acc_wdata = mdr;  // LDA; no other opcode reaches EXEC
            endcase
            stateNext = FETCH1;
         end

         MEMWR: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = operandAddr;
            bus.mem_wdata = acc_rdata;
            if (bus.mem_ready) stateNext = FETCH1;
         end

         HALT: halted = 1'b1;

         default: stateNext = INIT;
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int OP_LDA = 0, OP_STA = 1, OP_ADD = 2, OP_SUB = 3;
   localparam int OP_AND = 4, OP_JMP = 5, OP_JZ = 6, OP_HLT = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mc_control_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   logic [ADDR_W-1:0] acc_addr, pc;
   logic [DATA_W-1:0] acc_wdata, acc_rdata;
   logic              acc_we, carry, halted;

   mc_control_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.master),
      .acc_addr  (acc_addr),
      .acc_wdata (acc_wdata),
      .acc_we    (acc_we),
      .acc_rdata (acc_rdata),
      .carry     (carry),
      .halted    (halted),
      .pc        (pc)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // ---------------- accumulator register file model ----------------
   logic [7:0] accReg;
   always @(posedge clk) begin
      if (rst)         accReg <= 8'h00;
      else if (acc_we) accReg <= acc_wdata;
   end
   assign acc_rdata = accReg;

   // ---------------- memory model + bus monitor ----------------
   logic [7:0]  mem    [0:8191];
   logic [7:0]  refMem [0:8191];
   int unsigned maxWait = 0;
   int unsigned waitCnt = 0;
   bit          stallOn = 0;
   logic [12:0] stallAddr = '0;
   bit          noise   = 0;
   bit          pending = 0;
   logic        savedWe;
   logic [12:0] savedAddr;
   logic [7:0]  savedWdata;
   int          stabViol   = 0;
   int          accWeCount = 0;
   logic [12:0] accessQ[$];

   always @(negedge clk) begin
      if (pending && !rst) begin
         if (bus.mem_req !== 1'b1 || bus.mem_we !== savedWe ||
             bus.mem_addr !== savedAddr || bus.mem_wdata !== savedWdata)
            stabViol++;
      end
      if (acc_we === 1'b1) accWeCount++;
      if (rst) begin
         waitCnt = $urandom_range(maxWait, 0);
         accessQ.delete();
         bus.mem_ready = 1'b0;
         bus.mem_rdata = 8'h00;
      end else if (bus.mem_req === 1'b1) begin
         if (waitCnt > 0 || (stallOn && bus.mem_addr == stallAddr)) begin
            if (waitCnt > 0) waitCnt--;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 8'($urandom);
         end else begin
            bus.mem_ready = 1'b1;
            if (bus.mem_we) begin
               mem[bus.mem_addr] = bus.mem_wdata;
               bus.mem_rdata     = 8'($urandom);
            end else begin
               bus.mem_rdata = mem[bus.mem_addr];
            end
            accessQ.push_back(bus.mem_addr);
            waitCnt = $urandom_range(maxWait, 0);
         end
      end else begin
         bus.mem_ready = noise ? 1'($urandom_range(1, 0)) : 1'b0;
         bus.mem_rdata = 8'($urandom);
      end
      pending    = !rst && bus.mem_req === 1'b1 && !bus.mem_ready;
      savedWe    = bus.mem_we;
      savedAddr  = bus.mem_addr;
      savedWdata = bus.mem_wdata;
   end

   // ---------------- helpers ----------------
   task automatic clearMem();
      for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
   endtask

   task automatic putInstr(input int addr, input int op, input int a);
      mem[addr % 8192]       = 8'((op << 5) | (a >> 8));
      mem[(addr + 1) % 8192] = 8'(a & 255);
   endtask

   task automatic doReset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic runToHalt(input int budget, input string name);
      int c = 0;
      while (halted !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({name, "_halt_reached"}, halted, 1);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] qAt(input int i);
      return (i < accessQ.size()) ? 32'(accessQ[i]) : 32'hDEAD_BEEF;
   endfunction

   // Instruction-level reference model working on refMem.
   task automatic runModel(output int mAcc, output int mCarry, output int mPc,
                           output int mHalted, output int mWrites);
      int acc = 0, c = 0, p = 0, w = 0, h = 0;
      for (int step = 0; step < 500 && h == 0; step++) begin
         int hi, lo, op, a, m;
         hi = int'(refMem[p]);
         lo = int'(refMem[(p + 1) % 8192]);
         p  = (p + 2) % 8192;
         op = hi / 32;
         a  = (hi % 32) * 256 + lo;
         m  = int'(refMem[a]);
         case (op)
            OP_LDA: begin acc = m; w++; end
            OP_STA: refMem[a] = 8'(acc);
            OP_ADD: begin c = (acc + m > 255) ? 1 : 0; acc = (acc + m) % 256; w++; end
            OP_SUB: begin c = (acc < m) ? 1 : 0; acc = (acc - m + 256) % 256; w++; end
            OP_AND: begin acc = acc & m; w++; end
            OP_JMP: p = a;
            OP_JZ:  if (acc == 0) p = a;
            default: h = 1;
         endcase
      end
      mAcc = acc; mCarry = c; mPc = p; mHalted = h; mWrites = w;
   endtask

   typedef struct {
      int         op;
      logic [7:0] accInit;
      logic [7:0] operand;
      logic [7:0] expAcc;
      logic       expCarry;
   } aluVec_t;

   aluVec_t vec[8];

   initial begin
      int w, c, p0;
      vec[0] = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1};
      vec[1] = '{OP_ADD, 8'h01, 8'h02, 8'h03, 1'b0};
      vec[2] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1};
      vec[3] = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1};
      vec[4] = '{OP_SUB, 8'h07, 8'h05, 8'h02, 1'b0};
      vec[5] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0};
      vec[6] = '{OP_AND, 8'hF3, 8'h3C, 8'h30, 1'b0};
      vec[7] = '{OP_LDA, 8'h11, 8'h5A, 8'h5A, 1'b0};

      // ---- reset state and first-request latency ----
      clearMem();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      check("rst_mem_req",   bus.mem_req,   0);
      check("rst_mem_we",    bus.mem_we,    0);
      check("rst_mem_addr",  bus.mem_addr,  0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_acc_we",    acc_we,        0);
      check("rst_acc_wdata", acc_wdata,     0);
      check("rst_acc_addr",  acc_addr,      0);
      check("rst_halted",    halted,        0);
      check("rst_pc",        pc,            0);
      check("rst_carry",     carry,         0);
      rst = 1'b0;
      @(negedge clk);
      check("init_no_req", bus.mem_req, 0);
      @(negedge clk);
      check("first_req",      bus.mem_req,  1);
      check("first_req_addr", bus.mem_addr, 0);

      // ---- reference program, zero-wait, cycle count ----
      clearMem();
      putInstr(0, OP_LDA, 'h100);
      putInstr(2, OP_ADD, 'h101);
      putInstr(4, OP_STA, 'h102);
      putInstr(6, OP_HLT, 0);
      mem['h100] = 8'hF0;
      mem['h101] = 8'h20;
      maxWait = 0;
      doReset();
      p0 = accWeCount;
      w = 0;
      @(negedge clk);
      while (bus.mem_req !== 1'b1 && w < 10) begin @(negedge clk); w++; end
      c = 0;
      while (halted !== 1'b1 && c < 100) begin @(negedge clk); c++; end
      check("prog_cycles_to_halt", c, 17);
      @(posedge clk); #1;
      check("prog_store",   mem['h102], 8'h10);
      check("prog_carry",   carry, 1);
      check("prog_halted",  halted, 1);
      check("prog_acc_we",  accWeCount - p0, 2);

      // HALT absorbs: no requests despite ready noise
      noise = 1;
      w = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.mem_req !== 1'b0 || halted !== 1'b1) w++;
      end
      noise = 0;
      check("halt_hold_violations", w, 0);
      check("halt_pc", pc, 8);
      doReset();
      check("halted_clears_on_rst", halted, 0);

      // ---- single ALU op table ----
      for (int i = 0; i < 8; i++) begin
         clearMem();
         putInstr(0, OP_LDA, 'h100);
         putInstr(2, vec[i].op, 'h101);
         putInstr(4, OP_STA, 'h102);
         putInstr(6, OP_HLT, 0);
         mem['h100] = vec[i].accInit;
         mem['h101] = vec[i].operand;
         doReset();
         runToHalt(200, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_result", i), mem['h102], vec[i].expAcc);
         check($sformatf("vec%0d_carry", i),  carry,      vec[i].expCarry);
      end

      // ---- SUB then AND: carry kept by AND ----
      clearMem();
      putInstr(0, OP_LDA, 'h100);
      putInstr(2, OP_SUB, 'h101);
      putInstr(4, OP_AND, 'h102);
      putInstr(6, OP_STA, 'h103);
      putInstr(8, OP_HLT, 0);
      mem['h100] = 8'h05; mem['h101] = 8'h07; mem['h102] = 8'h0F;
      doReset();
      runToHalt(200, "suband");
      check("suband_acc",   accReg,     8'h0E);
      check("suband_store", mem['h103], 8'h0E);
      check("suband_carry", carry,      1);

      // ---- JZ taken / not taken ----
      for (int t = 0; t < 2; t++) begin
         clearMem();
         putInstr(0, OP_LDA, 'h100);
         putInstr(2, OP_JZ,  'h040);
         putInstr(4, OP_HLT, 0);
         putInstr('h40, OP_HLT, 0);
         mem['h100] = 8'(t);
         doReset();
         runToHalt(200, $sformatf("jz%0d", t));
         check($sformatf("jz%0d_pc", t), pc, (t == 0) ? 'h42 : 6);
      end

      // ---- JMP to top of memory, fetch wraps ----
      clearMem();
      putInstr(0, OP_JMP, 'h1FFF);
      mem[8191] = 8'hE0;
      doReset();
      runToHalt(200, "wrap");
      check("wrap_n_access", accessQ.size(), 4);
      check("wrap_addr0", qAt(0), 0);
      check("wrap_addr1", qAt(1), 1);
      check("wrap_addr2", qAt(2), 8191);
      check("wrap_addr3", qAt(3), 0);
      check("wrap_pc",    pc, 1);

      // ---- reset during MEMRD of an ADD ----
      clearMem();
      putInstr(0, OP_ADD, 'h101);
      putInstr(2, OP_HLT, 0);
      mem['h101] = 8'h33;
      stallAddr = 13'h101;
      stallOn   = 1;
      doReset();
      w = 0;
      @(negedge clk);
      while (!(bus.mem_req === 1'b1 && bus.mem_addr === 13'h101) && w < 50) begin
         @(negedge clk); w++;
      end
      check("midrst_reached_memrd", {bus.mem_req, bus.mem_addr}, {1'b1, 13'h101});
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      p0  = accWeCount;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_req_dropped", bus.mem_req, 0);
      check("midrst_pc",          pc, 0);
      check("midrst_no_acc_we",   accWeCount - p0, 0);
      stallOn = 0;
      rst     = 1'b0;
      runToHalt(200, "midrst");
      check("midrst_restart_addr", qAt(0), 0);
      check("midrst_acc",          accReg, 8'h33);
      check("midrst_acc_we",       accWeCount - p0, 1);
      check("midrst_pc_end",       pc, 4);

      // ---- random programs, 0-3 wait states, ready noise ----
      maxWait = 3;
      noise   = 1;
      for (int prog = 0; prog < 20; prog++) begin
         int n, op, tgt, mAcc, mCarry, mPc, mHalted, mWrites;
         clearMem();
         n = 10;
         for (int s = 0; s < n; s++) begin
            op = $urandom_range(6, 0);
            if (op == OP_JMP || op == OP_JZ) begin
               tgt = $urandom_range(n, s + 1);
               putInstr(2 * s, op, 2 * tgt);
            end else begin
               putInstr(2 * s, op, 'h100 + $urandom_range(15, 0));
            end
         end
         putInstr(2 * n, OP_HLT, 0);
         for (int k = 'h100; k < 'h110; k++) mem[k] = 8'($urandom);
         for (int k = 0; k < 8192; k++) refMem[k] = mem[k];
         runModel(mAcc, mCarry, mPc, mHalted, mWrites);
         doReset();
         p0 = accWeCount;
         runToHalt(2000, $sformatf("rnd%0d", prog));
         check($sformatf("rnd%0d_acc", prog),    accReg,          mAcc);
         check($sformatf("rnd%0d_carry", prog),  carry,           mCarry);
         check($sformatf("rnd%0d_pc", prog),     pc,              mPc);
         check($sformatf("rnd%0d_halted", prog), halted,          mHalted);
         check($sformatf("rnd%0d_acc_we", prog), accWeCount - p0, mWrites);
         for (int k = 'h100; k < 'h110; k++)
            check($sformatf("rnd%0d_mem%0h", prog, k), mem[k], refMem[k]);
      end
      noise = 0;
      check("bus_stable_while_waiting", stabViol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
